// File: rtl/ka60_seq_ctrl.sv
// ka60_seq_ctrl: sequential controller for a 60x60-bit carry-less (GF(2)[x]) multiply.
// It uses one shared external HW x HW combinational Karatsuba core. The three
// sub-products are issued on consecutive cycles: upper halves, lower halves, then the
// XOR-folded halves. Each product is captured and the result is assembled by XOR only.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active-high
//   in_valid_i   operand pair valid
//   in_ready_o   controller can accept operands (IDLE only)
//   a_i, b_i     operands, 2*HW bits (bit i = coefficient of x^i)
//   out_valid_o  result valid (DONE only)
//   out_ready_i  consumer accepts the result
//   o_o          carry-less product, 4*HW-1 bits; held until the next result
//   busy_o       high in any state other than IDLE
//   mul_a_o      core operand A, HW bits
//   mul_b_o      core operand B, HW bits
//   mul_p_i      core product, 2*HW-1 bits, combinational from mul_a_o/mul_b_o
module ka60_seq_ctrl #(
   parameter int unsigned HW = 30
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2*HW-1:0]   a_i,
   input  logic [2*HW-1:0]   b_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [4*HW-2:0]   o_o,
   output logic              busy_o,
   output logic [HW-1:0]     mul_a_o,
   output logic [HW-1:0]     mul_b_o,
   input  logic [2*HW-2:0]   mul_p_i
);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StHi   = 3'd1,
      StLo   = 3'd2,
      StMid  = 3'd3,
      StDone = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [2*HW-1:0]   a_q, a_d;
   logic [2*HW-1:0]   b_q, b_d;
   logic [2*HW-2:0]   t1_q, t1_d;
   logic [2*HW-2:0]   t0_q, t0_d;
   logic [4*HW-2:0]   o_q, o_d;
   logic [2*HW-2:0]   mid_sum;

   // Middle Karatsuba term: T2 ^ T1 ^ T0, valid while the core sees the folded halves.
   assign mid_sum = t0_q ^ t1_q ^ mul_p_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         t1_q    <= '0;
         t0_q    <= '0;
         o_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         t1_q    <= t1_d;
         t0_q    <= t0_d;
         o_q     <= o_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      t1_d    = t1_q;
      t0_d    = t0_q;
      o_d     = o_q;
      mul_a_o = '0;
      mul_b_o = '0;
      case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               state_d = StHi;
            end
         end
         StHi: begin
            mul_a_o = a_q[2*HW-1:HW];
            mul_b_o = b_q[2*HW-1:HW];
            t1_d    = mul_p_i;
            state_d = StLo;
         end
         StLo: begin
            mul_a_o = a_q[HW-1:0];
            mul_b_o = b_q[HW-1:0];
            t0_d    = mul_p_i;
            state_d = StMid;
         end
         StMid: begin
            mul_a_o = a_q[2*HW-1:HW] ^ a_q[HW-1:0];
            mul_b_o = b_q[2*HW-1:HW] ^ b_q[HW-1:0];
            o_d     = {t1_q, {(2*HW){1'b0}}}
                    ^ {{HW{1'b0}}, mid_sum, {HW{1'b0}}}
                    ^ {{(2*HW){1'b0}}, t0_q};
            state_d = StDone;
         end
         StDone: begin
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         // Unused encodings fall back to IDLE; out_valid is low there.
         default: state_d = StIdle;
      endcase
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign busy_o      = (state_q != StIdle);
   assign o_o         = o_q;

endmodule

// File: tb/tb_ka60_seq_ctrl.sv
// Self-checking bench for ka60_seq_ctrl: a behavioural core model drives mul_p and a
// shift-and-XOR carry-less reference produces every expected result.
module tb_ka60_seq_ctrl;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [59:0]   a;
   logic [59:0]   b;
   logic          out_valid;
   logic          out_ready;
   logic [118:0]  o;
   logic          busy;
   logic [29:0]   mul_a;
   logic [29:0]   mul_b;
   logic [58:0]   mul_p;

   int checks   = 0;
   int failures = 0;

   ka60_seq_ctrl #(.HW(30)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .o_o         (o),
      .busy_o      (busy),
      .mul_a_o     (mul_a),
      .mul_b_o     (mul_b),
      .mul_p_i     (mul_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [58:0] clmul30(input logic [29:0] x, input logic [29:0] y);
      logic [58:0] r;
      r = '0;
      for (int i = 0; i < 30; i++) begin
         if (y[i]) r = r ^ (59'(x) << i);
      end
      return r;
   endfunction

   function automatic logic [118:0] clmul60(input logic [59:0] x, input logic [59:0] y);
      logic [118:0] r;
      r = '0;
      for (int i = 0; i < 60; i++) begin
         if (y[i]) r = r ^ (119'(x) << i);
      end
      return r;
   endfunction

   // External combinational core.
   assign mul_p = clmul30(mul_a, mul_b);

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT expected in IDLE; returns at the negedge after the
   // DONE->IDLE edge. hold = cycles of out_ready low while in DONE.
   task automatic run_op(input logic [59:0] ta, input logic [59:0] tb, input logic [118:0] exp,
                         input int hold);
      int n;
      logic [118:0] held;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 128'(in_ready), 128'(1));
      in_valid = 1'b1;
      a = ta;
      b = tb;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      // HI: inputs are no longer honoured, so scramble them.
      in_valid = 1'($urandom_range(0, 1));
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      check("hi_mul_a", 128'(mul_a), 128'(ta[59:30]));
      check("hi_mul_b", 128'(mul_b), 128'(tb[59:30]));
      check("hi_in_ready", 128'(in_ready), 128'(0));
      check("hi_busy", 128'(busy), 128'(1));
      @(negedge clk);
      check("lo_mul_a", 128'(mul_a), 128'(ta[29:0]));
      check("lo_mul_b", 128'(mul_b), 128'(tb[29:0]));
      @(negedge clk);
      check("mid_mul_a", 128'(mul_a), 128'(ta[59:30] ^ ta[29:0]));
      check("mid_mul_b", 128'(mul_b), 128'(tb[59:30] ^ tb[29:0]));
      check("mid_out_valid", 128'(out_valid), 128'(0));
      out_ready = 1'b0;
      @(negedge clk);
      check("done_out_valid", 128'(out_valid), 128'(1));
      check("done_o", 128'(o), 128'(exp));
      check("done_mul_a", 128'(mul_a), 128'(0));
      held = exp;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a = {$urandom(), $urandom()};
         b = {$urandom(), $urandom()};
         @(negedge clk);
         check("bp_out_valid", 128'(out_valid), 128'(1));
         check("bp_o_stable", 128'(o), 128'(held));
         check("bp_in_ready", 128'(in_ready), 128'(0));
      end
      // in_valid stays as left above through the release edge; DONE must not accept it.
      out_ready = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("idle_out_valid", 128'(out_valid), 128'(0));
      check("idle_in_ready", 128'(in_ready), 128'(1));
      check("idle_busy", 128'(busy), 128'(0));
      check("idle_o_held", 128'(o), 128'(held));
   endtask

   initial begin
      logic [59:0] ra;
      logic [59:0] rb;
      logic [59:0] ones;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_o", 128'(o), 128'(0));
      check("rst_mul_a", 128'(mul_a), 128'(0));
      check("rst_mul_b", 128'(mul_b), 128'(0));
      rst = 1'b0;

      run_op(60'd1, 60'd1, 119'd1, 0);
      run_op(60'd3, 60'd3, 119'd5, 0);
      run_op((60'd5 << 30) | 60'd3, 60'd1, (119'd5 << 30) | 119'd3, 1);
      run_op(60'd1 << 59, 60'd1 << 59, 119'd1 << 118, 0);
      run_op(60'd1 << 30, 60'd3, 119'hC000_0000, 2);
      ones = '1;
      run_op(ones, ones, clmul60(ones, ones), 0);
      // Backpressure with competing in_valid during DONE.
      run_op(60'h0AB_CDEF_0123_4567, 60'h765_4321_0FED_CBA9,
             clmul60(60'h0AB_CDEF_0123_4567, 60'h765_4321_0FED_CBA9), 10);

      // Reset while in MID.
      in_valid = 1'b1;
      a = 60'h123_4567_89AB_CDEF;
      b = 60'h0FE_DCBA_9876_5432;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_busy", 128'(busy), 128'(1));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_out_valid", 128'(out_valid), 128'(0));
      check("mrst_o", 128'(o), 128'(0));
      check("mrst_in_ready", 128'(in_ready), 128'(1));
      check("mrst_busy", 128'(busy), 128'(0));
      check("mrst_mul_a", 128'(mul_a), 128'(0));
      run_op(60'd3, 60'd3, 119'd5, 0);

      for (int k = 0; k < 1000; k++) begin
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         run_op(ra, rb, clmul60(ra, rb), int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
